demux_sequencer: RTL and testbench
==================================

DEMUX_SEQUENCER -- requirements
Module: demux_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 1, SHALL set the number of clock cycles each enabled channel is driven; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_data  input  4  word to distribute; bit k is destined for demux channel k.
REQ-005 in_mask  input  4  channel enable, sampled with in_data; bit k=1 means channel k is driven.
REQ-006 in_valid  input  1  upstream offers in_data/in_mask this cycle.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 dmx_a  output  1  data bit to the 1-to-4 demux data input.
REQ-009 dmx_s  output  2  channel select to the demux select input.
REQ-010 frame_start  output  1  one-cycle pulse in the first DRIVE cycle of a word.
REQ-011 frame_done  output  1  one-cycle pulse when a word is fully distributed.
REQ-012 busy  output  1  high whenever state is not IDLE or a word is pending.

Function
REQ-013 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1, and written into a one-entry pending buffer.
REQ-014 in_ready SHALL equal NOT pending_valid, from registered state only; no combinational path from in_valid to in_ready.
REQ-015 A word offered while in_ready=0 SHALL be ignored; upstream holds it.
REQ-016 FSM states SHALL be IDLE, DRIVE, DONE.
REQ-017 IDLE: if pending_valid, pop pending into working register; if popped mask nonzero go DRIVE, else go DONE.
REQ-018 A word accepted at edge N SHALL be popped at edge N+1, first DRIVE output visible after edge N+1.
REQ-019 DRIVE: dmx_s SHALL equal current channel, dmx_a SHALL equal working in_data[dmx_s]; channel held exactly HOLD_CYCLES cycles via hold counter.
REQ-020 Channels SHALL be visited in ascending index order, skipping masked-off channels with no idle cycle between consecutive enabled channels.
REQ-021 After the highest enabled channel completes its hold, FSM SHALL go DONE.
REQ-022 DONE: lasts exactly one cycle; frame_done=1, dmx_a=0, dmx_s holds last value; then behaves as IDLE (pop pending if valid, else IDLE).
REQ-023 All-zero mask: word consumed, one DONE cycle with frame_done=1, no DRIVE cycle, frame_start stays 0.
REQ-024 Outside DRIVE, dmx_a SHALL be 0; in IDLE dmx_s SHALL be 0.
REQ-025 Pop and accept in the same cycle: when pending is popped, in_ready rises the following cycle (one-bubble), never same cycle.
REQ-026 Throughput: a word with k enabled channels SHALL occupy k*HOLD_CYCLES+1 cycles from first DRIVE to end of DONE.
REQ-027 All outputs except in_ready and busy SHALL be registered.

Reset
REQ-028 rst_n=0 SHALL immediately clear: state=IDLE, pending_valid=0, working register=0, hold counter=0, dmx_a=0, dmx_s=0, frame_start=0, frame_done=0, busy=0, in_ready=1.
REQ-029 Reset mid-DRIVE SHALL abandon the in-flight and pending words with no frame_done pulse; first edge after release is plain IDLE.

Structure
REQ-030 Package demux_seq_pkg SHALL hold the state enum (IDLE, DRIVE, DONE), HOLD counter width constant (4), and channel-count constant (4).
REQ-031 Pending buffer SHALL be one sub-module demux_seq_buf (data+mask register, valid flag, push/pop); FSM, hold counter, next-channel search stay in demux_sequencer.

Verification
REQ-032 HOLD=1, data=4'b1010 mask=4'b1111 -> dmx_s 0,1,2,3 on four consecutive cycles, dmx_a 0,1,0,1, frame_start cycle 1, frame_done cycle 5.
REQ-033 HOLD=3, data=4'b0110 mask=4'b0101 -> dmx_s=0 (a=0) three cycles, then dmx_s=2 (a=1) three cycles, frame_done next cycle.
REQ-034 mask=4'b0000 -> single frame_done pulse one cycle after pop, dmx_a stays 0, no frame_start.
REQ-035 Continuous in_valid, two words mask=4'b1111, HOLD=1 -> second word DRIVE begins immediately after first DONE; in_ready low while pending full; no word lost or duplicated.
REQ-036 rst_n low during second channel of a frame -> dmx_a=0, dmx_s=0, in_ready=1 before next clock edge; no frame_done afterwards.

Source files
------------

// File: rtl/demux_seq_pkg.sv
// Shared types and constants for the demux sequencer.
// Holds the FSM state enum, word bundle and channel search.
package demux_seq_pkg;

  localparam int N_CH   = 4;
  localparam int CH_W   = 2;
  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [N_CH-1:0] data;
    logic [N_CH-1:0] mask;
  } word_t;

  // {found, index} of the lowest enabled channel after (or at) from
  function automatic logic [CH_W:0] next_ch(
    input logic [N_CH-1:0] m,
    input logic [CH_W-1:0] from,
    input logic            incl
  );
    logic [CH_W:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(from) ||
          (incl && i == int'(from))))
        r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_seq_if.sv
// Handshake and demux-drive bundle of the demux sequencer.
// master drives words in; slave is the sequencer.
interface demux_seq_if;
  import demux_seq_pkg::*;

  logic [N_CH-1:0] in_data;
  logic [N_CH-1:0] in_mask;
  logic            in_valid;
  logic            in_ready;
  logic            dmx_a;
  logic [CH_W-1:0] dmx_s;
  logic            frame_start;
  logic            frame_done;
  logic            busy;

  modport master (
    output in_data, in_mask, in_valid,
    input  in_ready, dmx_a, dmx_s,
    input  frame_start, frame_done, busy
  );

  modport slave (
    input  in_data, in_mask, in_valid,
    output in_ready, dmx_a, dmx_s,
    output frame_start, frame_done, busy
  );

endinterface

// File: rtl/demux_seq_buf.sv
// One-entry pending word buffer with push/pop.
// Push and pop never coincide: push needs it empty.
module demux_seq_buf
  import demux_seq_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  word_t push_word,
  output logic  valid,
  output word_t word
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      word  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      word  <= push_word;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_sequencer.sv
// Serialises a 4-bit word onto a 1-to-4 demux,
// one enabled channel at a time, HOLD_CYCLES each.
module demux_sequencer
  import demux_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input logic        clk,
  input logic        rst_n,
  demux_seq_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(HOLD_CYCLES - 1);

  state_e          state;
  word_t           work;
  word_t           pend_w;
  word_t           in_w;
  logic            pend_v;
  logic            push;
  logic            pop;
  logic [CH_W-1:0] chan;
  logic [HOLD_W-1:0] hold_cnt;
  logic            dmx_a_q;
  logic            fs_q;
  logic            fd_q;
  logic [CH_W:0]   first_nx;
  logic [CH_W:0]   adv_nx;

  assign in_w     = {bus.in_data, bus.in_mask};
  assign push     = bus.in_valid && !pend_v;
  assign pop      = pend_v && (state != DRIVE);
  assign first_nx = next_ch(pend_w.mask, '0, 1'b1);
  assign adv_nx   = next_ch(work.mask, chan, 1'b0);

  demux_seq_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_word (in_w),
    .valid     (pend_v),
    .word      (pend_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      work     <= '0;
      chan     <= '0;
      hold_cnt <= '0;
      dmx_a_q  <= 1'b0;
      fs_q     <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      fd_q <= 1'b0;
      unique case (state)
        DRIVE: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            if (adv_nx[CH_W]) begin
              chan    <= adv_nx[CH_W-1:0];
              dmx_a_q <= work.data[adv_nx[CH_W-1:0]];
            end else begin
              state   <= DONE;
              dmx_a_q <= 1'b0;
              fd_q    <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          // IDLE and the tail of DONE both take the next word
          if (pend_v) begin
            work <= pend_w;
            if (first_nx[CH_W]) begin
              state   <= DRIVE;
              chan    <= first_nx[CH_W-1:0];
              dmx_a_q <= pend_w.data[first_nx[CH_W-1:0]];
              fs_q    <= 1'b1;
            end else begin
              state   <= DONE;
              dmx_a_q <= 1'b0;
              fd_q    <= 1'b1;
            end
          end else begin
            state   <= IDLE;
            chan    <= '0;
            dmx_a_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready    = !pend_v;
  assign bus.busy        = (state != IDLE) || pend_v;
  assign bus.dmx_s       = chan;
  assign bus.dmx_a       = dmx_a_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_done  = fd_q;

endmodule

// File: tb/tb_demux_sequencer.sv
// Bench for demux_sequencer: HOLD 1 and HOLD 3 instances,
// directed vector table, corner sequences, random vs model.
module tb_demux_sequencer;
  import demux_seq_pkg::*;

  typedef struct {
    logic [3:0]  data;
    logic [3:0]  mask;
    int          dut;
    int          len;
    logic [15:0] a_seq;
    logic [31:0] s_seq;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_seq_if b0 ();
  demux_seq_if b1 ();

  logic       iv  [2];
  logic [3:0] idt [2];
  logic [3:0] imk [2];

  assign b0.in_valid = iv[0];
  assign b0.in_data  = idt[0];
  assign b0.in_mask  = imk[0];
  assign b1.in_valid = iv[1];
  assign b1.in_data  = idt[1];
  assign b1.in_mask  = imk[1];

  demux_sequencer #(.HOLD_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave)
  );
  demux_sequencer #(.HOLD_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );

  logic [1:0] os  [2];
  logic       oa  [2];
  logic       ofs [2];
  logic       ofd [2];
  logic       ordy[2];
  logic       obs [2];

  assign os[0]   = b0.dmx_s;
  assign oa[0]   = b0.dmx_a;
  assign ofs[0]  = b0.frame_start;
  assign ofd[0]  = b0.frame_done;
  assign ordy[0] = b0.in_ready;
  assign obs[0]  = b0.busy;
  assign os[1]   = b1.dmx_s;
  assign oa[1]   = b1.dmx_a;
  assign ofs[1]  = b1.frame_start;
  assign ofd[1]  = b1.frame_done;
  assign ordy[1] = b1.in_ready;
  assign obs[1]  = b1.busy;

  // reference model: pending slot plus active word and
  // cycle position inside that word's k*H+1 cycle frame
  int         hold_c[2];
  logic       pv    [2];
  logic       av    [2];
  logic [3:0] pwd   [2];
  logic [3:0] pwm   [2];
  logic [3:0] awd   [2];
  logic [3:0] awm   [2];
  int         pos   [2];
  logic [1:0] prev_s[2];
  logic       acc_f [2];

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tv[6];

  function automatic int wlen(input logic [3:0] m,
                              input int h);
    return $countones(m) * h + 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pv[d] = 0; av[d] = 0; pos[d] = 0;
      prev_s[d] = 0; acc_f[d] = 0;
      pwd[d] = 0; pwm[d] = 0; awd[d] = 0; awm[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int last;
      last = wlen(awm[d], hold_c[d]) - 1;
      acc_f[d] = iv[d] && !pv[d];
      if (pv[d] && (!av[d] || pos[d] == last)) begin
        awd[d] = pwd[d]; awm[d] = pwm[d];
        av[d] = 1; pos[d] = 0; pv[d] = 0;
      end else if (av[d]) begin
        if (pos[d] == last) av[d] = 0;
        else pos[d]++;
      end
      if (acc_f[d]) begin
        pwd[d] = idt[d]; pwm[d] = imk[d]; pv[d] = 1;
      end
    end
  endtask

  task automatic expect_out(input int d,
                            output logic [1:0] s,
                            output logic a, fs, fd);
    int k, h, n;
    s = 0; a = 0; fs = 0; fd = 0;
    if (av[d]) begin
      k = $countones(awm[d]);
      h = hold_c[d];
      if (pos[d] < k * h) begin
        n = pos[d] / h;
        for (int c = 0; c < 4; c++) begin
          if (awm[d][c]) begin
            if (n == 0) begin
              s = 2'(c); a = awd[d][c];
            end
            n--;
          end
        end
        fs = (pos[d] == 0);
      end else begin
        fd = 1;
        s = prev_s[d];
        for (int c = 0; c < 4; c++)
          if (awm[d][c]) s = 2'(c);
      end
    end
  endtask

  task automatic check_all();
    logic [1:0] s;
    logic a, fs, fd, rdy, bsy;
    for (int d = 0; d < 2; d++) begin
      expect_out(d, s, a, fs, fd);
      rdy = !pv[d];
      bsy = av[d] || pv[d];
      n_tests++;
      if ({os[d], oa[d], ofs[d], ofd[d], ordy[d], obs[d]} !==
          {s, a, fs, fd, rdy, bsy}) begin
        n_fail++;
        $display("FAIL model dut%0d t=%0t got s=%0d a=%b fs=%b fd=%b rdy=%b busy=%b exp s=%0d a=%b fs=%b fd=%b rdy=%b busy=%b",
                 d, $time, os[d], oa[d], ofs[d], ofd[d],
                 ordy[d], obs[d], s, a, fs, fd, rdy, bsy);
      end
      prev_s[d] = s;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic chk(input string name,
                     input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d",
               name, got, exp);
    end
  endtask

  initial begin
    hold_c[0] = 1;
    hold_c[1] = 3;
    tv[0] = '{data:4'b1010, mask:4'b1111, dut:0, len:5,
              a_seq:16'h000A, s_seq:32'h03E4};
    tv[1] = '{data:4'b0110, mask:4'b0101, dut:1, len:7,
              a_seq:16'h0038, s_seq:32'h2A80};
    tv[2] = '{data:4'b1111, mask:4'b0000, dut:0, len:1,
              a_seq:16'h0000, s_seq:32'h0000};
    tv[3] = '{data:4'b0100, mask:4'b1100, dut:0, len:3,
              a_seq:16'h0001, s_seq:32'h003E};
    tv[4] = '{data:4'b1001, mask:4'b1000, dut:1, len:4,
              a_seq:16'h0007, s_seq:32'h00FF};
    tv[5] = '{data:4'b0101, mask:4'b0011, dut:1, len:7,
              a_seq:16'h0007, s_seq:32'h1540};
    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; idt[d] = 0; imk[d] = 0;
    end
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;
    repeat (2) cycle();

    // directed single-word vectors
    for (int i = 0; i < 6; i++) begin
      int d;
      d = tv[i].dut;
      iv[d] = 1; idt[d] = tv[i].data; imk[d] = tv[i].mask;
      cycle();
      iv[d] = 0;
      cycle();
      for (int c = 0; c < tv[i].len; c++) begin
        logic [1:0] es;
        logic ea, efs, efd;
        es  = tv[i].s_seq[2*c +: 2];
        ea  = tv[i].a_seq[c];
        efs = (c == 0) && (tv[i].mask != 0);
        efd = (c == tv[i].len - 1);
        n_tests++;
        if ({os[d], oa[d], ofs[d], ofd[d]} !==
            {es, ea, efs, efd}) begin
          n_fail++;
          $display("FAIL vec%0d cyc%0d got s=%0d a=%b fs=%b fd=%b exp s=%0d a=%b fs=%b fd=%b",
                   i, c, os[d], oa[d], ofs[d], ofd[d],
                   es, ea, efs, efd);
        end
        cycle();
      end
      repeat (2) cycle();
    end

    // back-to-back words under continuous valid
    begin
      int sent, nfs, nfd, fs_c[2], fd_c[2];
      sent = 0; nfs = 0; nfd = 0;
      fs_c[0] = 0; fs_c[1] = 0; fd_c[0] = 0; fd_c[1] = 0;
      iv[0] = 1; idt[0] = 4'b0011; imk[0] = 4'b1111;
      for (int c = 0; c < 20; c++) begin
        cycle();
        if (ofs[0]) begin
          if (nfs < 2) fs_c[nfs] = c;
          nfs++;
        end
        if (ofd[0]) begin
          if (nfd < 2) fd_c[nfd] = c;
          nfd++;
        end
        if (acc_f[0]) begin
          sent++;
          if (sent == 1) idt[0] = 4'b1100;
          else iv[0] = 0;
        end
      end
      chk("b2b_sent", sent, 2);
      chk("b2b_starts", nfs, 2);
      chk("b2b_dones", nfd, 2);
      chk("b2b_gap", fs_c[1], fd_c[0] + 1);
    end

    // reset during the second channel of a frame
    begin
      int waited;
      for (int d = 0; d < 2; d++) begin
        iv[d] = 1; idt[d] = 4'b1010; imk[d] = 4'b1111;
      end
      cycle();
      idt[0] = 4'b0101; idt[1] = 4'b0101;
      waited = 0;
      while (os[0] != 2'd1 && waited < 10) begin
        cycle();
        waited++;
      end
      chk("rst_reach_ch1", int'(os[0]), 1);
      chk("rst_pending_full", int'(ordy[0]), 0);
      iv[0] = 0; iv[1] = 0;
      #2 rst_n = 0;
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_s", int'(os[d]), 0);
        chk("rst_a", int'(oa[d]), 0);
        chk("rst_rdy", int'(ordy[d]), 1);
        chk("rst_busy", int'(obs[d]), 0);
        chk("rst_fd", int'(ofd[d]), 0);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      repeat (8) cycle();
    end

    // random traffic against the model
    repeat (1500) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]  = ($urandom_range(0, 3) != 0);
        idt[d] = 4'($urandom);
        imk[d] = ($urandom_range(0, 7) == 0) ?
                 4'b0000 : 4'($urandom);
      end
      cycle();
    end
    iv[0] = 0; iv[1] = 0;
    repeat (40) cycle();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
